// File: rtl/sid_pot.sv
// SID paddle converter: measures POTX/POTY capacitor charge time over a 512-tick cycle.
// Optional SID_POT_SYNC_EN adds a two-flop synchroniser on each comparator input.
package sid;
  localparam int PHI0 = 0;
  localparam int PHI1 = 1;
  localparam int PHI2 = 2;
  localparam int PHI3 = 3;

  typedef logic [3:0] phase_t;
  typedef logic [8:0] reg9_t;

  typedef struct packed {
    logic [1:0] charged;
  } pot_i_t;

  typedef struct packed {
    logic discharge;
  } pot_o_t;

  typedef struct packed {
    logic [1:0][7:0] xy;
  } pot_reg_t;
endpackage

module sid_pot (
  input  logic          clk,
  input  logic          rst_n,
  input  sid::phase_t   phi,
  input  sid::pot_i_t   pot_i,
  output sid::pot_o_t   pot_o,
  output sid::pot_reg_t pot_reg
);

  logic            tick_s;
  logic            charge_phase_s;
  logic            latch_s;
  logic [1:0]      charged_s;
  logic            phi_unused_s;
  sid::reg9_t      cnt_q;
  sid::reg9_t      cnt_d;
  logic [1:0][7:0] pos_q;
  logic [1:0][7:0] pos_d;
  logic [1:0][7:0] xy_q;
  logic [1:0][7:0] xy_d;

  assign tick_s         = phi[sid::PHI1];
  assign phi_unused_s   = ^{phi[sid::PHI0], phi[sid::PHI2], phi[sid::PHI3]};
  assign charge_phase_s = cnt_q[8];
  assign latch_s        = (cnt_q == 9'd511);

`ifdef SID_POT_SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  // Comparator outputs are asynchronous to clk; resolve them every clk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= pot_i.charged;
      sync2_q <= sync1_q;
    end
  end

  assign charged_s = sync2_q;
`else
  assign charged_s = pot_i.charged;
`endif

  // Next-state: cycle counter, per-channel position counters and latched readings.
  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    xy_d  = xy_q;
    if (tick_s) begin
      cnt_d = cnt_q + 9'd1;
      for (int i = 0; i < 2; i++) begin
        if (!charge_phase_s) begin
          pos_d[i] = 8'd0;
        end else if (latch_s) begin
          // Last tick of the charge phase only publishes; at most 255 increments precede it.
          xy_d[i]  = pos_q[i];
          pos_d[i] = pos_q[i];
        end else if (!charged_s[i]) begin
          pos_d[i] = pos_q[i] + 8'd1;
        end else begin
          pos_d[i] = pos_q[i];
        end
      end
    end else begin
      cnt_d = cnt_q;
      pos_d = pos_q;
      xy_d  = xy_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 9'd0;
      pos_q <= {8'd0, 8'd0};
      xy_q  <= {8'd0, 8'd0};
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      xy_q  <= xy_d;
    end
  end

  assign pot_o.discharge = ~cnt_q[8];
  assign pot_reg.xy      = xy_q;

endmodule

// File: tb/tb_sid_pot.sv
// Directed bench for sid_pot: phi rotates every clk so a tick occurs every 4 clk.
module tb_sid_pot;

  logic          clk;
  logic          rst_n;
  sid::phase_t   phi;
  sid::pot_i_t   pot_i;
  sid::pot_o_t   pot_o;
  sid::pot_reg_t pot_reg;

  int         checks;
  int         errors;
  int         ph;
  logic [8:0] bcnt;
  int         ks [3];
  int         exp_pos;

`ifdef SID_POT_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  sid_pot dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .phi     (phi),
    .pot_i   (pot_i),
    .pot_o   (pot_o),
    .pot_reg (pot_reg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clk: after the edge, account for a tick, then present the next phase.
  task automatic clk1();
    @(posedge clk);
    #1;
    if (phi[sid::PHI1]) bcnt = bcnt + 9'd1;
    ph  = (ph + 1) % 4;
    phi = 4'b0001 << ph;
  endtask

  // Advance until the next edge lies k clk before the tick taken at cnt == target.
  task automatic goto(input logic [8:0] target, input int k);
    int n;
    n = 0;
    while (!(bcnt == target && ph == ((1 - k) & 3)) && n < 4000) begin
      clk1();
      n++;
    end
    chk("goto_bound", {15'd0, (n < 4000)}, 16'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    ph            = 0;
    bcnt          = 9'd0;
    phi           = 4'b0001;
    pot_i.charged = 2'b00;
    rst_n         = 1'b0;
    ks[0] = 0; ks[1] = 1; ks[2] = 3;

    #12;
    chk("reset_discharge", {15'd0, pot_o.discharge}, 16'd1);
    chk("reset_xy", pot_reg, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two full periods: discharge tracks the tick count, both channels charge freely.
    for (int i = 0; i < 2048; i++) begin
      clk1();
      chk("period_discharge", {15'd0, pot_o.discharge}, {15'd0, ~bcnt[8]});
    end
    chk("full_scale_xy", pot_reg, 16'hFFFF);

    // Channel 0 stops at tick 356 with various input lead times; channel 1 never counts.
    for (int j = 0; j < 3; j++) begin
      pot_i.charged = 2'b10;
      goto(9'd356, ks[j]);
      pot_i.charged = 2'b11;
      goto(9'd400, 0);
      if (j == 0) chk("xy_hold_mid_charge", pot_reg, 16'hFFFF);
      goto(9'd0, 0);
      exp_pos = (SYNC == 1 && ks[j] <= 1) ? 101 : 100;
      chk("split_channels", pot_reg, {8'd0, exp_pos[7:0]});
    end

    // Channel 0 glitches high for ticks 300..309, then resumes counting.
    pot_i.charged = 2'b00;
    goto(9'd300, 0);
    pot_i.charged = 2'b01;
    goto(9'd310, 0);
    pot_i.charged = 2'b00;
    goto(9'd0, 0);
    chk("glitch_xy", pot_reg, {8'd255, 8'd245});

    // Reset in the middle of a charge phase.
    goto(9'd300, 0);
    chk("pre_reset_discharge", {15'd0, pot_o.discharge}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset_discharge", {15'd0, pot_o.discharge}, 16'd1);
    chk("midreset_xy", pot_reg, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bcnt  = 9'd0;
    goto(9'd255, 0);
    chk("post_reset_discharge_255", {15'd0, pot_o.discharge}, 16'd1);
    goto(9'd256, 0);
    chk("post_reset_charge_256", {15'd0, pot_o.discharge}, 16'd0);
    goto(9'd511, 0);
    chk("post_reset_no_latch_yet", pot_reg, 16'h0000);
    goto(9'd0, 0);
    chk("post_reset_first_latch", pot_reg, 16'hFFFF);
    chk("post_reset_wrap_discharge", {15'd0, pot_o.discharge}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_pot.md
SID_POT -- requirements
Module: sid_pot

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock.
REQ-002 SHALL have port rst_n, input, 1 bit: reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have port phi, input, sid::phase_t (4 bits): one-hot SID phase; a "tick" is any clk edge with phi[sid::PHI1]=1.
REQ-004 SHALL have port pot_i, input, sid::pot_i_t: charged[0]=POTX, charged[1]=POTY comparator outputs (1 = capacitor above threshold).
REQ-005 SHALL have port pot_o, output, sid::pot_o_t: discharge=1 drives both POT pins low.
REQ-006 SHALL have port pot_reg, output, sid::pot_reg_t: xy[0]=POTX, xy[1]=POTY read-register values, consumed as read_reg_t.pot.

Function
REQ-007 SHALL hold a 9-bit cycle counter cnt (sid::reg9_t) that increments by 1 on every tick and wraps 511->0; no change on non-tick clk edges.
REQ-008 SHALL hold one 8-bit position counter pos[i] per channel (i=0,1).
REQ-009 SHALL drive pot_o.discharge = ~cnt[8] combinationally from the cnt register (discharge phase cnt 0..255, charge phase cnt 256..511; 256 ticks each, 512-tick period).
REQ-010 SHALL, on a tick with cnt[8]=0, clear pos[i] to 0.
REQ-011 SHALL, on a tick with 256<=cnt<=510, increment pos[i] by 1 iff the effective charged[i]=0; otherwise hold pos[i].
REQ-012 SHALL, on a tick with cnt=511, load pot_reg.xy[i] <= pos[i] (pre-tick value) and not increment pos[i].
REQ-013 SHALL never overflow pos[i]: at most 255 increments occur per charge phase (ticks at cnt 256..510), so the maximum latched value is 255 with no wrap or saturation logic required.
REQ-014 SHALL hold pot_reg.xy[i] constant between cnt=511 ticks; the two channels are fully independent.
REQ-015 SHALL treat charged[i] falling back to 0 mid-charge as resumed counting (no sticky stop); the latched value equals the number of charge-phase ticks 256..510 with effective charged[i]=0.
REQ-016 SHALL ignore pot_i during the discharge phase.
REQ-017 SHALL treat phi with multiple bits set as a tick whenever phi[sid::PHI1]=1; other bits have no effect.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force cnt=0, pos[0]=pos[1]=0, pot_reg.xy=0 and any synchroniser flops to 0.
REQ-019 SHALL therefore output pot_o.discharge=1 and pot_reg=16'h0000 during and immediately after reset.
REQ-020 SHALL, on reset asserted mid-charge, discard the partial measurement; the first latch after release occurs at the 512th tick after release.

Configuration
REQ-021 SHALL support macro SID_POT_SYNC_EN.
REQ-022 SHALL, with SID_POT_SYNC_EN defined, pass each charged[i] through a two-flop synchroniser clocked every clk edge (2 clk latency) and use its output as the effective charged[i].
REQ-023 SHALL, without SID_POT_SYNC_EN, use pot_i.charged[i] directly as the effective charged[i] (0 latency).

Verification
REQ-024 SHALL verify reset: rst_n=0 mid-operation -> discharge=1, xy=0 immediately, cnt restarts at 0 after release.
REQ-025 SHALL verify period: ticks every 4 clk (phi rotating) -> discharge 1 for 256 ticks, 0 for 256 ticks, repeating every 512 ticks.
REQ-026 SHALL verify full scale: charged=2'b00 throughout -> after first cnt=511 tick, xy[0]=xy[1]=8'd255.
REQ-027 SHALL verify split channels (macro off): charged[0] rises at the tick where cnt=356, charged[1]=1 always -> xy[0]=8'd100, xy[1]=8'd0.
REQ-028 SHALL verify mid-charge glitch: charged[0]=1 during cnt 300..309 only, else 0 -> xy[0]=8'd245.
REQ-029 SHALL verify SID_POT_SYNC_EN: charged[0] edge 1 clk before the cnt=356 tick -> xy[0]=8'd101; edge 3 clk before -> xy[0]=8'd100.
